// File: rtl/vertex_fetch_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : vertex_fetch_engine_if
// Brief    : Start, consumer-FIFO, memory-port and status signals of the
//            vertex fetch engine.
// Revision : 1.0
// ============================================================================
interface vertex_fetch_engine_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 7
) ();
    logic [ADDR_W-1:0] v_addr_in;
    logic              valid_in;
    logic              ready_out;
    logic              pos_deq_in;
    logic [DATA_W-1:0] pos_data_out;
    logic              pos_valid_out;
    logic              neigh_deq_in;
    logic [DATA_W-1:0] neigh_data_out;
    logic              neigh_valid_out;
    logic              pmem_req_valid_out;
    logic [ADDR_W-1:0] pmem_req_addr_out;
    logic              pmem_req_ready_in;
    logic              pmem_rsp_valid_in;
    logic [DATA_W-1:0] pmem_rsp_data_in;
    logic              nmem_req_valid_out;
    logic [ADDR_W-1:0] nmem_req_addr_out;
    logic              nmem_req_ready_in;
    logic              nmem_rsp_valid_in;
    logic [DATA_W-1:0] nmem_rsp_data_in;
    logic              done_out;
    logic [CNT_W-1:0]  neigh_count_out;
    logic              trunc_out;

    modport slave (
        input  v_addr_in, valid_in, pos_deq_in, neigh_deq_in,
        input  pmem_req_ready_in, pmem_rsp_valid_in, pmem_rsp_data_in,
        input  nmem_req_ready_in, nmem_rsp_valid_in, nmem_rsp_data_in,
        output ready_out, pos_data_out, pos_valid_out, neigh_data_out, neigh_valid_out,
        output pmem_req_valid_out, pmem_req_addr_out, nmem_req_valid_out, nmem_req_addr_out,
        output done_out, neigh_count_out, trunc_out
    );

    modport master (
        output v_addr_in, valid_in, pos_deq_in, neigh_deq_in,
        output pmem_req_ready_in, pmem_rsp_valid_in, pmem_rsp_data_in,
        output nmem_req_ready_in, nmem_rsp_valid_in, nmem_rsp_data_in,
        input  ready_out, pos_data_out, pos_valid_out, neigh_data_out, neigh_valid_out,
        input  pmem_req_valid_out, pmem_req_addr_out, nmem_req_valid_out, nmem_req_addr_out,
        input  done_out, neigh_count_out, trunc_out
    );
endinterface
`default_nettype wire

// File: rtl/vertex_fetch_engine.sv
`default_nettype none
// ============================================================================
// Module   : vertex_fetch_engine (+ vertex_fetch_engine_fifo)
// Brief    : Credit-based fetch of a vertex's position words and zero-
//            terminated neighbour list into two output FIFOs.
// Revision : 1.0
// ============================================================================
module vertex_fetch_engine_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic                         enq,
    input  wire logic [W-1:0]                 din,
    input  wire logic                         deq,
    output logic      [W-1:0]                 dout,
    output logic                              valid,
    output logic      [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          do_enq, do_deq;

    always_comb begin
        do_deq = deq && (count != '0);
        do_enq = enq && (32'(count) < DEPTH);
        valid  = (count != '0);
        dout   = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= (32'(wr_ptr) == DEPTH-1) ? '0 : wr_ptr + AW'(1);
            end
            if (do_deq)
                rd_ptr <= (32'(rd_ptr) == DEPTH-1) ? '0 : rd_ptr + AW'(1);
            count <= count + CW'(do_enq) - CW'(do_deq);
        end
    end
endmodule

module vertex_fetch_engine #(
    parameter int DIM         = 2,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int POS_DEPTH   = 4,
    parameter int NEIGH_DEPTH = 4,
    parameter int MAX_OUTST   = 4,
    parameter int MAX_NEIGH   = 64
) (
    input  wire logic             clk_in,
    input  wire logic             rst_in,
    vertex_fetch_engine_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_NEIGH+1);
    localparam int OW    = $clog2(MAX_OUTST+1);
    localparam int PW    = $clog2(POS_DEPTH+1);
    localparam int NW    = $clog2(NEIGH_DEPTH+1);
    localparam int IW    = $clog2(DIM+1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pos_addr, neigh_addr;
    logic [IW-1:0]     pos_issued;
    logic [OW-1:0]     pos_outst, neigh_outst;
    logic [CNT_W-1:0]  neigh_enq;
    logic              stop, trunc;
    logic [PW-1:0]     pos_cnt;
    logic [NW-1:0]     neigh_cnt;

    logic start, pos_rsp_ok, neigh_rsp_ok, neigh_zero, neigh_push, stop_now;
    logic pos_more, neigh_more, pos_req, neigh_req, pos_fire, neigh_fire;

    always_comb begin
        start        = (state == IDLE) && bus.valid_in;
        // A response with nothing outstanding is stale (e.g. issued before a reset).
        pos_rsp_ok   = bus.pmem_rsp_valid_in && (pos_outst != '0);
        neigh_rsp_ok = bus.nmem_rsp_valid_in && (neigh_outst != '0);
        neigh_zero   = neigh_rsp_ok && !stop && (bus.nmem_rsp_data_in == '0);
        neigh_push   = neigh_rsp_ok && !stop && (bus.nmem_rsp_data_in != '0);
        stop_now     = stop || neigh_zero;
        pos_more     = 32'(pos_issued) < DIM;
        neigh_more   = !stop_now && (32'(neigh_enq) + 32'(neigh_outst) < MAX_NEIGH);
        // Credit: stored + in-flight never exceeds FIFO depth, so a response always fits.
        pos_req      = (state == FETCH) && pos_more && (32'(pos_outst) < MAX_OUTST)
                       && (32'(pos_cnt) + 32'(pos_outst) < POS_DEPTH);
        neigh_req    = (state == FETCH) && neigh_more && (32'(neigh_outst) < MAX_OUTST)
                       && (32'(neigh_cnt) + 32'(neigh_outst) < NEIGH_DEPTH);
        pos_fire     = pos_req && bus.pmem_req_ready_in;
        neigh_fire   = neigh_req && bus.nmem_req_ready_in;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.valid_in) state_nxt = FETCH;
            FETCH:   if (!pos_more && !neigh_more) state_nxt = DRAIN;
            DRAIN:   if ((pos_outst == '0) && (neigh_outst == '0)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= IDLE;
            pos_addr    <= '0;
            neigh_addr  <= '0;
            pos_issued  <= '0;
            pos_outst   <= '0;
            neigh_outst <= '0;
            neigh_enq   <= '0;
            stop        <= 1'b0;
            trunc       <= 1'b0;
        end else begin
            state       <= state_nxt;
            pos_outst   <= pos_outst + OW'(pos_fire) - OW'(pos_rsp_ok);
            neigh_outst <= neigh_outst + OW'(neigh_fire) - OW'(neigh_rsp_ok);
            if (start) begin
                pos_addr   <= bus.v_addr_in + ADDR_W'(1);
                neigh_addr <= bus.v_addr_in + ADDR_W'(DIM + 1);
                pos_issued <= '0;
                neigh_enq  <= '0;
                stop       <= 1'b0;
                trunc      <= 1'b0;
            end else begin
                if (pos_fire) begin
                    pos_addr   <= pos_addr + ADDR_W'(1);
                    pos_issued <= pos_issued + IW'(1);
                end
                if (neigh_fire)
                    neigh_addr <= neigh_addr + ADDR_W'(1);
                if (neigh_zero)
                    stop <= 1'b1;
                if (neigh_push)
                    neigh_enq <= neigh_enq + CNT_W'(1);
                if ((state == DRAIN) && (state_nxt == DONE))
                    trunc <= !stop && (32'(neigh_enq) == MAX_NEIGH);
            end
        end
    end

    vertex_fetch_engine_fifo #(.DEPTH(POS_DEPTH), .W(DATA_W)) u_pos_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .enq   (pos_rsp_ok),
        .din   (bus.pmem_rsp_data_in),
        .deq   (bus.pos_deq_in),
        .dout  (bus.pos_data_out),
        .valid (bus.pos_valid_out),
        .count (pos_cnt)
    );

    vertex_fetch_engine_fifo #(.DEPTH(NEIGH_DEPTH), .W(DATA_W)) u_neigh_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .enq   (neigh_push),
        .din   (bus.nmem_rsp_data_in),
        .deq   (bus.neigh_deq_in),
        .dout  (bus.neigh_data_out),
        .valid (bus.neigh_valid_out),
        .count (neigh_cnt)
    );

    assign bus.ready_out          = (state == IDLE);
    assign bus.done_out           = (state == DONE);
    assign bus.neigh_count_out    = neigh_enq;
    assign bus.trunc_out          = trunc;
    assign bus.pmem_req_valid_out = pos_req;
    assign bus.pmem_req_addr_out  = pos_addr;
    assign bus.nmem_req_valid_out = neigh_req;
    assign bus.nmem_req_addr_out  = neigh_addr;
endmodule
`default_nettype wire

// File: doc/vertex_fetch_engine.md
Name: vertex_fetch_engine

Overview:
Parametrised next-generation vertex fetcher for the graph pipeline. Given a vertex record base address, it streams DIM position words and a zero-terminated neighbour list from two independent read ports into two output FIFOs. Issue is credit-based, so FIFOs never overflow, and multiple requests may be in flight per port. It reports completion, neighbour count and truncation to the scheduler.

Parameters:
DIM, 2, position words per vertex (1..16)
DATA_W, 32, data word width
ADDR_W, 32, address width
POS_DEPTH, 4, position FIFO depth (>= 1)
NEIGH_DEPTH, 4, neighbour FIFO depth (>= 1)
MAX_OUTST, 4, max in-flight requests per port
MAX_NEIGH, 64, neighbour cap per vertex; list is truncated at this count

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous, active-high reset
v_addr_in  in  ADDR_W  vertex record base address
valid_in  in  1  start request; accepted only when ready_out=1
ready_out  out  1  high in IDLE
pos_deq_in  in  1  pop position FIFO
pos_data_out  out  DATA_W  position FIFO head
pos_valid_out  out  1  position FIFO not empty
neigh_deq_in  in  1  pop neighbour FIFO
neigh_data_out  out  DATA_W  neighbour FIFO head
neigh_valid_out  out  1  neighbour FIFO not empty
pmem_req_valid_out  out  1  position read request
pmem_req_addr_out  out  ADDR_W  position read address
pmem_req_ready_in  in  1  memory accepts request
pmem_rsp_valid_in  in  1  position read response, in order
pmem_rsp_data_in  in  DATA_W  response data
nmem_req_valid_out, nmem_req_addr_out, nmem_req_ready_in, nmem_rsp_valid_in, nmem_rsp_data_in: same as pmem_*, neighbour port
done_out  out  1  one-cycle pulse when the vertex is complete
neigh_count_out  out  $clog2(MAX_NEIGH+1)  neighbours enqueued for the last vertex; held until next start
trunc_out  out  1  set with done_out if MAX_NEIGH was reached without a terminator; held until next start

Behaviour:
- Reset: FSM=IDLE, ready_out=1, both FIFOs empty, all req_valid=0, done_out=0, neigh_count_out=0, trunc_out=0, all counters 0. Reset mid-operation aborts immediately. Responses arriving after reset are ignored.
- Record layout: position words at base+1..base+DIM; neighbours at base+1+DIM onward. A neighbour value of 0 terminates the list and is never enqueued.
- FSM states IDLE -> FETCH -> DRAIN -> DONE -> IDLE.
  - IDLE: valid_in latches base. Next cycle is FETCH. Clears counters, neigh_count_out and trunc_out.
  - FETCH: both ports issue concurrently. A request fires on req_valid && req_ready. Addresses increment by 1 per fired request.
  - Position port: issues exactly DIM requests. req_valid only when pos_outst < MAX_OUTST and pos_fifo_count + pos_outst < POS_DEPTH.
  - Neighbour port: issues speculatively under the same credit rule with NEIGH_DEPTH. It stops when a 0 response arrives (stop flag) or when enqueued + in-flight reaches MAX_NEIGH.
  - FETCH -> DRAIN once neither port will issue further.
  - DRAIN: wait until pos_outst=0 and neigh_outst=0.
  - Neighbour responses arriving after the stop flag is set are dropped but still decrement the count. The stop flag applies in the same cycle as a zero response.
  - DRAIN -> DONE.
  - DONE: done_out=1 for one cycle, then IDLE. ready_out=1 again on the cycle after DONE.
- Completion does not wait for the FIFOs to be drained by the consumer.
- valid_in while not IDLE is ignored.
- Credit rule: a response is always enqueueable. The FIFO never sees enq while full.
- FIFO enq and deq in the same cycle: count is unchanged. Enq into an empty FIFO: data is visible the next cycle (registered, 1-cycle latency).
- Deq on an empty FIFO is ignored.
- Outstanding counters:
  - +1 on a fired request, -1 on a response, net 0 when both occur in the same cycle.
  - A response with outstanding=0 is an error: ignored, no underflow.
- trunc_out=1 iff MAX_NEIGH neighbours were enqueued and no zero was seen among accepted responses.
- Address arithmetic wraps modulo 2^ADDR_W.

Test Plan:
- DIM=2, 1-cycle memory, base=0x10, mem[0x11..0x12]=7,9, mem[0x13..]=5,6,0; consumer always deqs -> pos stream 7,9; neigh stream 5,6; done_out pulses once; neigh_count_out=2; trunc_out=0.
- Same record, consumer never deqs, NEIGH_DEPTH=2 -> at most 2 neighbour requests outstanding+stored; no FIFO overflow. After a later deq, 0 is fetched and done_out follows.
- Empty list mem[base+1+DIM]=0, MAX_OUTST=4, 3-cycle latency -> speculative responses after 0 are dropped; neigh_count_out=0; done_out only after neigh_outst=0.
- MAX_NEIGH=3, list 1,2,3,4,0 -> exactly 3 enqueued; trunc_out=1; neigh_count_out=3.
- pmem_req_ready_in toggled randomly, 5-cycle latency -> position order preserved; addresses base+1..base+DIM issued exactly once each.
- rst_in asserted mid-FETCH with responses in flight -> next cycle ready_out=1 and FIFOs empty. A new vertex then completes correctly, ignoring stale responses.
